req_issuer: RTL

REQ_ISSUER -- requirements
Module: req_issuer

---
 rtl/req_issuer_pkg.sv | 14 +
 rtl/req_issuer_if.sv | 26 ++
 rtl/req_issuer_chan.sv | 82 ++++++++
 rtl/req_issuer.sv | 61 ++++++
 4 files changed

// File: rtl/req_issuer_pkg.sv
// Shared definitions for the request issuer: client FSM states and default sizing.
package req_issuer_pkg;

    localparam int unsigned N_CLIENTS  = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned STARVE_LIM = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_t;

endpackage

// File: rtl/req_issuer_if.sv
// Bus between the request issuer and its clients / downstream priority selector.
interface req_issuer_if;
    import req_issuer_pkg::*;

    logic [N_CLIENTS-1:0]       push;
    logic [N_CLIENTS-1:0]       gnt;
    logic [N_CLIENTS-1:0]       req;
    logic                       en;
    logic [N_CLIENTS*CNT_W-1:0] pend;
    logic [N_CLIENTS-1:0]       full;
    logic [N_CLIENTS-1:0]       done;
    logic [N_CLIENTS-1:0]       starve;
    logic [N_CLIENTS-1:0]       ovf;
    logic                       err;

    modport master (
        output push, gnt,
        input  req, en, pend, full, done, starve, ovf, err
    );

    modport slave (
        input  push, gnt,
        output req, en, pend, full, done, starve, ovf, err
    );

endinterface

// File: rtl/req_issuer_chan.sv
// One client channel: pending counter, IDLE/REQ/HOLD FSM, starvation timer and overflow flag.
module req_issuer_chan #(
    parameter int unsigned CNT_W      = req_issuer_pkg::CNT_W,
    parameter int unsigned STARVE_LIM = req_issuer_pkg::STARVE_LIM
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             grant,
    input  logic             freeze,
    output logic             req,
    output logic [CNT_W-1:0] pend,
    output logic             full,
    output logic             done,
    output logic             starve,
    output logic             ovf
);
    import req_issuer_pkg::*;

    localparam int unsigned      SW   = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0]    LIM  = SW'(STARVE_LIM);
    localparam logic [CNT_W-1:0] CMAX = '1;

    chan_state_t      state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [SW-1:0]    scnt, nxt_scnt;
    logic             acc, drop;

    // Next-state, counter and starvation-timer computation for this client
    always_comb begin
        acc      = grant && (state == ST_REQ);
        drop     = push && !acc && (cnt == CMAX);
        nxt_cnt  = cnt;
        if (push && !acc && (cnt != CMAX)) begin
            nxt_cnt = cnt + CNT_W'(1);
        end else if (acc && !push) begin
            nxt_cnt = cnt - CNT_W'(1);
        end

        nxt_state = state;
        unique case (state)
            ST_IDLE: if (push) nxt_state = ST_REQ;
            ST_REQ:  if (acc)  nxt_state = ST_HOLD;
            ST_HOLD: nxt_state = (nxt_cnt != '0) ? ST_REQ : ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase

        if ((state == ST_REQ) && !acc) begin
            nxt_scnt = (scnt == LIM) ? scnt : scnt + SW'(1);
        end else begin
            nxt_scnt = '0;
        end
    end

    // Client FSM with registered outputs; an illegal grant elsewhere freezes everything but done
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            scnt   <= '0;
            req    <= 1'b0;
            full   <= 1'b0;
            done   <= 1'b0;
            starve <= 1'b0;
            ovf    <= 1'b0;
        end else if (freeze) begin
            done <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            scnt   <= nxt_scnt;
            req    <= (nxt_state == ST_REQ);
            full   <= (nxt_cnt == CMAX);
            done   <= acc;
            starve <= (nxt_scnt >= LIM);
            if (drop) ovf <= 1'b1;
        end
    end

    assign pend = cnt;

endmodule

// File: rtl/req_issuer.sv
// Request issuer top: grant legality check, sticky error flag and one channel per client.
module req_issuer #(
    parameter int unsigned N_CLIENTS  = req_issuer_pkg::N_CLIENTS,
    parameter int unsigned CNT_W      = req_issuer_pkg::CNT_W,
    parameter int unsigned STARVE_LIM = req_issuer_pkg::STARVE_LIM
) (
    input  logic         clock,
    input  logic         reset,
    req_issuer_if.slave  bus
);
    import req_issuer_pkg::*;

    logic [N_CLIENTS-1:0]       req_v, full_v, done_v, starve_v, ovf_v, grant_v;
    logic [N_CLIENTS*CNT_W-1:0] pend_v;
    logic                       gnt_onehot, gnt_illegal, err_q;

    // Classify the incoming grant: multi-hot, or aimed at a client not currently requesting
    always_comb begin
        gnt_onehot  = $onehot(bus.gnt);
        gnt_illegal = ((bus.gnt != '0) && !gnt_onehot) || ((bus.gnt & ~req_v) != '0);
        grant_v     = gnt_onehot ? bus.gnt : '0;
    end

    // Sticky illegal-grant flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (gnt_illegal) begin
            err_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_chan
        req_issuer_chan #(
            .CNT_W      (CNT_W),
            .STARVE_LIM (STARVE_LIM)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .push   (bus.push[i]),
            .grant  (grant_v[i]),
            .freeze (gnt_illegal),
            .req    (req_v[i]),
            .pend   (pend_v[i*CNT_W +: CNT_W]),
            .full   (full_v[i]),
            .done   (done_v[i]),
            .starve (starve_v[i]),
            .ovf    (ovf_v[i])
        );
    end

    assign bus.req    = req_v;
    assign bus.en     = |req_v;
    assign bus.pend   = pend_v;
    assign bus.full   = full_v;
    assign bus.done   = done_v;
    assign bus.starve = starve_v;
    assign bus.ovf    = ovf_v;
    assign bus.err    = err_q;

endmodule
